// File: rtl/adc_clk_gen_prog.sv
// Programmable ADC clock generator: divides clk by a runtime period with programmable
// high time, and emits a phase-programmable sample strobe and a period-start marker.
module adc_clk_gen_prog #(
  parameter int CNT_W         = 16,
  parameter int DEFAULT_DIV   = 32768,
  parameter int DEFAULT_HIGH  = 16384,
  parameter int DEFAULT_PHASE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_phase,
  output logic             clk_out,
  output logic             sample_stb,
  output logic             period_start,
  output logic             running,
  output logic             cfg_err
);

  localparam logic [CNT_W-1:0] ZERO      = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE       = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TWO       = {{(CNT_W-2){1'b0}}, 2'b10};
  localparam logic [CNT_W-1:0] DIV_RST   = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] HIGH_RST  = CNT_W'(DEFAULT_HIGH);
  localparam logic [CNT_W-1:0] PHASE_RST = CNT_W'(DEFAULT_PHASE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_t;

  function automatic logic cfg_ok(input logic [CNT_W-1:0] d,
                                  input logic [CNT_W-1:0] h,
                                  input logic [CNT_W-1:0] p);
    return (d >= TWO) && (h != ZERO) && (h < d) && (p < d);
  endfunction

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_high;
  logic [CNT_W-1:0] r_phase;
  logic [CNT_W-1:0] r_sh_div;
  logic [CNT_W-1:0] r_sh_high;
  logic [CNT_W-1:0] r_sh_phase;
  logic             r_pending;
  logic             r_clk_out;
  logic             r_sample_stb;
  logic             r_period_start;
  logic             r_cfg_err;

  logic             w_accept;
  logic             w_cfg_valid_ok;
  logic             w_boundary;
  logic             w_apply;
  logic [CNT_W-1:0] w_high_n;
  logic [CNT_W-1:0] w_phase_n;
  logic [CNT_W-1:0] w_cnt_n;
  logic             w_clk_n;
  logic             w_stb_n;
  logic             w_ps_n;

  // Handshake, boundary detection and the counter/outputs of the next counting cycle.
  always_comb begin
    w_accept       = cfg_valid && !r_pending;
    w_cfg_valid_ok = cfg_ok(cfg_div, cfg_high, cfg_phase);
    w_boundary     = (r_state != S_IDLE) && (r_cnt == (r_div - ONE));
    w_apply        = r_pending && ((r_state == S_IDLE) || w_boundary);
    if (w_apply) begin
      w_high_n  = r_sh_high;
      w_phase_n = r_sh_phase;
    end else begin
      w_high_n  = r_high;
      w_phase_n = r_phase;
    end
    if (w_boundary) begin
      w_cnt_n = ZERO;
    end else begin
      w_cnt_n = r_cnt + ONE;
    end
    w_clk_n = (w_cnt_n < w_high_n);
    w_stb_n = (w_cnt_n == w_phase_n);
    w_ps_n  = (w_cnt_n == ZERO);
  end

  // Config shadow/active registers; new settings only take effect on a period boundary or in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div      <= DIV_RST;
      r_high     <= HIGH_RST;
      r_phase    <= PHASE_RST;
      r_sh_div   <= DIV_RST;
      r_sh_high  <= HIGH_RST;
      r_sh_phase <= PHASE_RST;
      r_pending  <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_cfg_err <= w_accept && !w_cfg_valid_ok;
      // Accept needs !pending and apply needs pending, so the two never collide.
      if (w_apply) begin
        r_div     <= r_sh_div;
        r_high    <= r_sh_high;
        r_phase   <= r_sh_phase;
        r_pending <= 1'b0;
      end else if (w_accept && w_cfg_valid_ok) begin
        r_sh_div   <= cfg_div;
        r_sh_high  <= cfg_high;
        r_sh_phase <= cfg_phase;
        r_pending  <= 1'b1;
      end else begin
        r_pending <= r_pending;
      end
    end
  end

  // Run/stop state machine with the period counter and registered clock/strobe outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= ZERO;
      r_clk_out      <= 1'b0;
      r_sample_stb   <= 1'b0;
      r_period_start <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= ZERO;
          if (en) begin
            r_state        <= S_RUN;
            r_clk_out      <= 1'b1;
            r_sample_stb   <= (w_phase_n == ZERO);
            r_period_start <= 1'b1;
          end else begin
            r_state        <= S_IDLE;
            r_clk_out      <= 1'b0;
            r_sample_stb   <= 1'b0;
            r_period_start <= 1'b0;
          end
        end
        S_RUN: begin
          r_state        <= en ? S_RUN : S_STOP;
          r_cnt          <= w_cnt_n;
          r_clk_out      <= w_clk_n;
          r_sample_stb   <= w_stb_n;
          r_period_start <= w_ps_n;
        end
        S_STOP: begin
          // Re-enable wins over the stop boundary so a running clock is never interrupted.
          if (en || !w_boundary) begin
            r_state        <= en ? S_RUN : S_STOP;
            r_cnt          <= w_cnt_n;
            r_clk_out      <= w_clk_n;
            r_sample_stb   <= w_stb_n;
            r_period_start <= w_ps_n;
          end else begin
            r_state        <= S_IDLE;
            r_cnt          <= ZERO;
            r_clk_out      <= 1'b0;
            r_sample_stb   <= 1'b0;
            r_period_start <= 1'b0;
          end
        end
        default: begin
          r_state        <= S_IDLE;
          r_cnt          <= ZERO;
          r_clk_out      <= 1'b0;
          r_sample_stb   <= 1'b0;
          r_period_start <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready    = !r_pending;
  assign running      = (r_state != S_IDLE);
  assign clk_out      = r_clk_out;
  assign sample_stb   = r_sample_stb;
  assign period_start = r_period_start;
  assign cfg_err      = r_cfg_err;

endmodule

// File: tb/tb_adc_clk_gen_prog.sv
// Scoreboard bench for adc_clk_gen_prog: a cycle-level reference model pushes expected
// outputs per clock, a separate monitor pops and compares them against the DUT.
module tb_adc_clk_gen_prog;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_div;
  logic [15:0] cfg_high;
  logic [15:0] cfg_phase;
  logic        clk_out;
  logic        sample_stb;
  logic        period_start;
  logic        running;
  logic        cfg_err;

  adc_clk_gen_prog dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_div     (cfg_div),
    .cfg_high    (cfg_high),
    .cfg_phase   (cfg_phase),
    .clk_out     (clk_out),
    .sample_stb  (sample_stb),
    .period_start(period_start),
    .running     (running),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic clk_out;
    logic stb;
    logic ps;
    logic running;
    logic ready;
    logic err;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: mode 0 idle, 1 running, 2 stopping; pos is the position within the period.
  int m_div, m_high, m_phase;
  int s_div, s_high, s_phase;
  bit m_pend, m_took, m_err;
  int m_mode, m_pos;

  task automatic chk(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  task automatic model_reset();
    m_div = 32768; m_high = 16384; m_phase = 0;
    s_div = 32768; s_high = 16384; s_phase = 0;
    m_pend = 1'b0; m_took = 1'b0; m_err = 1'b0;
    m_mode = 0; m_pos = 0;
  endtask

  task automatic model_step();
    int  d, h, p, old_div;
    bit  acc, ok, at_end;
    exp_t e;
    d = int'(cfg_div); h = int'(cfg_high); p = int'(cfg_phase);
    acc     = cfg_valid && !m_pend;
    ok      = (d >= 2) && (h >= 1) && (h < d) && (p < d);
    old_div = m_div;
    at_end  = (m_mode != 0) && (m_pos == old_div - 1);
    if (m_pend && (m_mode == 0 || at_end)) begin
      m_div = s_div; m_high = s_high; m_phase = s_phase;
      m_pend = 1'b0;
    end else if (acc && ok) begin
      s_div = d; s_high = h; s_phase = p;
      m_pend = 1'b1;
    end
    m_took = acc;
    m_err  = acc && !ok;
    if (m_mode == 0) begin
      if (en) begin m_mode = 1; m_pos = 0; end
    end else begin
      m_pos = (m_pos + 1) % old_div;
      if (en) m_mode = 1;
      else if (m_mode == 1) m_mode = 2;
      else if (m_pos == 0) m_mode = 0;
    end
    if (m_mode == 0) begin
      e.clk_out = 1'b0; e.stb = 1'b0; e.ps = 1'b0;
    end else begin
      e.clk_out = (m_pos < m_high);
      e.stb     = (m_pos == m_phase);
      e.ps      = (m_pos == 0);
    end
    e.running = (m_mode != 0);
    e.ready   = !m_pend;
    e.err     = m_err;
    q.push_back(e);
  endtask

  // Model runs on each clock edge (and resets asynchronously with the DUT).
  initial begin
    exp_t r;
    model_reset();
    r = '{clk_out: 1'b0, stb: 1'b0, ps: 1'b0, running: 1'b0, ready: 1'b1, err: 1'b0};
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        model_reset();
        if (clk) q.push_back(r);
      end else begin
        model_step();
      end
    end
  end

  // Monitor: compares DUT outputs against the oldest expectation just after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        bound_fail("scoreboard_empty");
      end else begin
        e = q.pop_front();
        chk("clk_out", clk_out, e.clk_out);
        chk("sample_stb", sample_stb, e.stb);
        chk("period_start", period_start, e.ps);
        chk("running", running, e.running);
        chk("cfg_ready", cfg_ready, e.ready);
        chk("cfg_err", cfg_err, e.err);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic offer(input int d, input int h, input int p);
    cfg_valid = 1'b1;
    cfg_div = 16'(d); cfg_high = 16'(h); cfg_phase = 16'(p);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_pos(input int p);
    int k = 0;
    while (!(m_mode != 0 && m_pos == p) && k < 40000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40000) bound_fail("wait_pos");
  endtask

  task automatic wait_ready();
    int k = 0;
    while (m_pend && k < 40000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40000) bound_fail("wait_ready");
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; cfg_valid = 1'b0;
    cfg_div = 16'd0; cfg_high = 16'd0; cfg_phase = 16'd0;
    #2;
    chk("reset_clk_out", clk_out, 1'b0);
    chk("reset_running", running, 1'b0);
    chk("reset_cfg_ready", cfg_ready, 1'b1);
    tick(3);
    reset = 1'b0;
    tick(2);

    // 1: div=4 high=1 phase=2 loaded in IDLE, then run
    offer(4, 1, 2);
    tick(2);
    en = 1'b1;
    tick(13);

    // 2: switch to 4/2, then offer 6/3 mid-period at cnt=1
    offer(4, 2, 0);
    tick(8);
    wait_pos(1);
    offer(6, 3, 0);
    tick(16);

    // 3: invalid configs each pulse cfg_err and leave the running pattern alone
    offer(8, 8, 0);
    tick(1);
    offer(1, 0, 0);
    tick(1);
    offer(8, 1, 8);
    chk("ready_after_bad", cfg_ready, 1'b1);
    tick(8);

    // 4: div=10 high=5, stop at cnt=3, then stop/re-raise at cnt=7
    offer(10, 5, 0);
    tick(14);
    wait_pos(3);
    en = 1'b0;
    tick(12);
    chk("stopped_running", running, 1'b0);
    chk("stopped_clk_out", clk_out, 1'b0);
    en = 1'b1;
    tick(3);
    wait_pos(3);
    en = 1'b0;
    wait_pos(7);
    en = 1'b1;
    tick(15);

    // 5: offer exactly on the boundary cycle
    offer(5, 2, 4);
    tick(12);
    wait_pos(4);
    offer(7, 3, 6);
    tick(20);

    // Random phase: en toggling, valid/invalid offers held until taken
    for (int i = 0; i < 1500; i++) begin
      if (!cfg_valid || m_took) begin
        if ($urandom_range(0, 3) == 0) begin
          int d;
          d = int'($urandom_range(1, 12));
          cfg_valid = 1'b1;
          cfg_div   = 16'(d);
          cfg_high  = 16'($urandom_range(0, d));
          cfg_phase = 16'($urandom_range(0, d));
        end else begin
          cfg_valid = 1'b0;
        end
      end
      if ($urandom_range(0, 19) == 0) en = ~en;
      @(negedge clk);
    end
    cfg_valid = 1'b0;

    // 6: reset mid-period with a pending config, then run on defaults
    en = 1'b1;
    tick(2);
    wait_ready();
    offer(10, 5, 0);
    wait_ready();
    offer(9, 4, 1);
    wait_pos(2);
    chk("pend_before_reset", cfg_ready, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_clk_out", clk_out, 1'b0);
    chk("async_stb", sample_stb, 1'b0);
    chk("async_ps", period_start, 1'b0);
    chk("async_running", running, 1'b0);
    chk("async_cfg_ready", cfg_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick(32768 + 40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
